// File: rtl/fp_issue_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// fp_issue_ctrl_pkg
// Shared definitions for the FP issue/writeback controller:
//   - default latency, issue gap, register count and register-file width
//   - fp_inflight_t : one in-flight op record {v, rd, rd_en} at the default
//     register count
//   - sat_inc16     : saturating 16-bit increment used by the statistics
//     counters
// ----------------------------------------------------------------------------
package fp_issue_ctrl_pkg;

    localparam int FP_LATENCY_DEF   = 2;
    localparam int FP_ISSUE_GAP_DEF = 2;
    localparam int FP_NUM_REGS      = 32;
    localparam int FP_REG_IDX_W     = $clog2(FP_NUM_REGS);
    localparam int FP_REGFILE_WIDTH = 32;

    typedef struct packed {
        logic                    v;
        logic [FP_REG_IDX_W-1:0] rd;
        logic                    rd_en;
    } fp_inflight_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        logic [15:0] res;
        if (val == 16'hFFFF) begin
            res = val;
        end else begin
            res = val + 16'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// ----------------------------------------------------------------------------
// fp_scoreboard
// One pending bit per FP register. A bit is set when an op writing that
// register issues and cleared when that op writes back. When set and clear
// target the same index in one cycle, the set wins.
// Ports:
//   clk, rst           clock, asynchronous active-high reset (clears all bits)
//   set_en / set_idx   mark a destination pending
//   clr_en / clr_idx   release a destination at writeback
//   rs1_idx/rs1_pend   read port for source 1
//   rs2_idx/rs2_pend   read port for source 2
//   rd_idx /rd_pend    read port for the destination (WAW check)
// ----------------------------------------------------------------------------
module fp_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic [IDX_W-1:0] rs1_idx,
    input  logic [IDX_W-1:0] rs2_idx,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rs1_pend,
    output logic             rs2_pend,
    output logic             rd_pend
);

    logic [NUM_REGS-1:0] pend_r;
    logic [NUM_REGS-1:0] set_mask_s;
    logic [NUM_REGS-1:0] clr_mask_s;
    logic [NUM_REGS-1:0] pend_next_s;

    // Decode set/clear requests into one-hot masks and form the next state.
    always_comb begin
        set_mask_s = '0;
        clr_mask_s = '0;
        if (set_en) begin
            set_mask_s[set_idx] = 1'b1;
        end else begin
            set_mask_s = '0;
        end
        if (clr_en) begin
            clr_mask_s[clr_idx] = 1'b1;
        end else begin
            clr_mask_s = '0;
        end
        // Clear first, then set, so a same-index collision leaves the bit set.
        pend_next_s = (pend_r & ~clr_mask_s) | set_mask_s;
    end

    // Pending-bit register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r <= '0;
        end else begin
            pend_r <= pend_next_s;
        end
    end

    // Read ports see the registered state only, so no bypass from writeback.
    always_comb begin
        rs1_pend = pend_r[rs1_idx];
        rs2_pend = pend_r[rs2_idx];
        rd_pend  = pend_r[rd_idx];
    end

endmodule

// File: rtl/fp_issue_ctrl.sv
// ----------------------------------------------------------------------------
// fp_issue_ctrl
// Decode-side issue/writeback controller for the FP execute unit (FEX).
// Accepts decoded ops on dec_valid/dec_ready, strobes fp_inst_valid on the
// issue cycle, tracks in-flight ops in an FP_LATENCY-deep pipe and presents
// the destination index plus FEX result at writeback. A per-register pending
// scoreboard stalls RAW and WAW hazards; a shadow model of FEX busy and
// busy_er raises a sticky proto_err on disagreement.
//
// Optional feature macro: FP_ISSUE_STATS_EN
//   defined   : stat_issued / stat_stall saturating 16-bit counters
//   undefined : stat_* tied to 0, no counter flops
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   dec_valid / dec_ready        decoded op handshake (dec_ready combinational)
//   dec_rs1/rs2, dec_rs1/2_en    source indices and read enables
//   dec_rd, dec_rd_en            destination index and write enable
//   fp_inst_valid                issue strobe to FEX
//   fex_busy, fex_busy_er        FEX busy / early busy release
//   fex_result, fex_err          FEX result and error at writeback
//   wb_valid, wb_rd, wb_data,
//   wb_err                       writeback to the register file
//   proto_err                    sticky busy-mismatch flag
//   stat_issued, stat_stall      statistics counters
// ----------------------------------------------------------------------------
module fp_issue_ctrl
    import fp_issue_ctrl_pkg::*;
#(
    parameter int FP_LATENCY    = FP_LATENCY_DEF,
    parameter int ISSUE_GAP     = FP_ISSUE_GAP_DEF,
    parameter int NUM_REGS      = FP_NUM_REGS,
    parameter int REGFILE_WIDTH = FP_REGFILE_WIDTH,
    parameter int REG_IDX_W     = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dec_valid,
    output logic                     dec_ready,
    input  logic [REG_IDX_W-1:0]     dec_rs1,
    input  logic [REG_IDX_W-1:0]     dec_rs2,
    input  logic                     dec_rs1_en,
    input  logic                     dec_rs2_en,
    input  logic [REG_IDX_W-1:0]     dec_rd,
    input  logic                     dec_rd_en,
    output logic                     fp_inst_valid,
    input  logic                     fex_busy,
    input  logic                     fex_busy_er,
    input  logic [REGFILE_WIDTH-1:0] fex_result,
    input  logic                     fex_err,
    output logic                     wb_valid,
    output logic [REG_IDX_W-1:0]     wb_rd,
    output logic [REGFILE_WIDTH-1:0] wb_data,
    output logic                     wb_err,
    output logic                     proto_err,
    output logic [15:0]              stat_issued,
    output logic [15:0]              stat_stall
);

    localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(ISSUE_GAP - 1);

    // In-flight record sized to this instance's register count.
    typedef struct packed {
        logic                 v;
        logic [REG_IDX_W-1:0] rd;
        logic                 rd_en;
    } inflight_t;

    inflight_t [FP_LATENCY-1:0] pipe_r;
    inflight_t                  head_s;
    inflight_t                  tail_s;

    logic [GAP_W-1:0] gap_cnt_r;
    logic             gap_ok_s;
    logic             haz_s;
    logic             issue_s;
    logic             rs1_pend_s;
    logic             rs2_pend_s;
    logic             rd_pend_s;
    logic             clr_en_s;
    logic             exp_busy_s;
    logic             exp_er_s;
    logic             mismatch_s;
    logic             proto_err_r;

    fp_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (REG_IDX_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue_s & dec_rd_en),
        .set_idx  (dec_rd),
        .clr_en   (clr_en_s),
        .clr_idx  (tail_s.rd),
        .rs1_idx  (dec_rs1),
        .rs2_idx  (dec_rs2),
        .rd_idx   (dec_rd),
        .rs1_pend (rs1_pend_s),
        .rs2_pend (rs2_pend_s),
        .rd_pend  (rd_pend_s)
    );

    // Issue decision: minimum gap elapsed and no RAW/WAW hazard on the offered op.
    always_comb begin
        haz_s    = (dec_rs1_en & rs1_pend_s) | (dec_rs2_en & rs2_pend_s) | (dec_rd_en & rd_pend_s);
        gap_ok_s = (gap_cnt_r == '0);
        // Held low while in reset so nothing can be accepted into a clearing pipe.
        if (rst) begin
            dec_ready = 1'b0;
        end else begin
            dec_ready = gap_ok_s & ~haz_s;
        end
        issue_s       = dec_valid & dec_ready;
        fp_inst_valid = issue_s;
    end

    // Head entry entering the pipe and tail entry leaving it.
    always_comb begin
        head_s.v     = issue_s;
        head_s.rd    = dec_rd;
        head_s.rd_en = dec_rd_en;
        tail_s       = pipe_r[FP_LATENCY-1];
        clr_en_s     = tail_s.v & tail_s.rd_en;
    end

    // Issue-gap down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt_r <= '0;
        end else if (issue_s) begin
            gap_cnt_r <= GAP_LOAD;
        end else if (gap_cnt_r != '0) begin
            gap_cnt_r <= gap_cnt_r - GAP_W'(1);
        end else begin
            gap_cnt_r <= gap_cnt_r;
        end
    end

    // In-flight shift register; the tail lines up with the FEX result cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_r <= '0;
        end else begin
            pipe_r[0] <= head_s;
            for (int i = 1; i < FP_LATENCY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    // Writeback: data and error pass through only while the tail is valid.
    always_comb begin
        wb_valid = tail_s.v;
        wb_rd    = tail_s.rd;
        if (tail_s.v) begin
            wb_data = fex_result;
            wb_err  = fex_err;
        end else begin
            wb_data = '0;
            wb_err  = 1'b0;
        end
    end

    // Shadow FEX busy model: busy covers the issue cycle and the one after,
    // early release is the cycle after issue.
    always_comb begin
        exp_busy_s = issue_s | pipe_r[0].v;
        exp_er_s   = pipe_r[0].v;
        mismatch_s = (exp_busy_s != fex_busy) | (exp_er_s != fex_busy_er);
    end

    // Sticky protocol error flag; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err_r <= 1'b0;
        end else begin
            proto_err_r <= proto_err_r | mismatch_s;
        end
    end

    assign proto_err = proto_err_r;

`ifdef FP_ISSUE_STATS_EN
    logic [15:0] stat_issued_r;
    logic [15:0] stat_stall_r;

    // Saturating issue and stall-cycle counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued_r <= 16'h0000;
            stat_stall_r  <= 16'h0000;
        end else begin
            if (issue_s) begin
                stat_issued_r <= sat_inc16(stat_issued_r);
            end else begin
                stat_issued_r <= stat_issued_r;
            end
            if (dec_valid & ~dec_ready) begin
                stat_stall_r <= sat_inc16(stat_stall_r);
            end else begin
                stat_stall_r <= stat_stall_r;
            end
        end
    end

    assign stat_issued = stat_issued_r;
    assign stat_stall  = stat_stall_r;
`else
    assign stat_issued = 16'h0000;
    assign stat_stall  = 16'h0000;
`endif

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fp_issue_ctrl
// Directed bench for fp_issue_ctrl with a writeback scoreboard queue and a
// small FEX busy model. Statistics expectations follow FP_ISSUE_STATS_EN.
// ----------------------------------------------------------------------------
module tb_fp_issue_ctrl;

    localparam int LAT = 2;
    localparam int GAP = 2;
    localparam int NR  = 32;
    localparam int RW  = 32;
    localparam int IW  = 5;

`ifdef FP_ISSUE_STATS_EN
    localparam logic [15:0] EXP_ISSUED = 16'd3;
    localparam logic [15:0] EXP_STALL  = 16'd4;
`else
    localparam logic [15:0] EXP_ISSUED = 16'd0;
    localparam logic [15:0] EXP_STALL  = 16'd0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          dec_valid;
    logic          dec_ready;
    logic [IW-1:0] dec_rs1;
    logic [IW-1:0] dec_rs2;
    logic          dec_rs1_en;
    logic          dec_rs2_en;
    logic [IW-1:0] dec_rd;
    logic          dec_rd_en;
    logic          fp_inst_valid;
    logic          fex_busy;
    logic          fex_busy_er;
    logic [RW-1:0] fex_result;
    logic          fex_err;
    logic          wb_valid;
    logic [IW-1:0] wb_rd;
    logic [RW-1:0] wb_data;
    logic          wb_err;
    logic          proto_err;
    logic [15:0]   stat_issued;
    logic [15:0]   stat_stall;

    logic force_busy_low;
    logic issue_d1;

    typedef struct {
        logic [IW-1:0] rd;
        int            due;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    int   wb_seen = 0;
    int   w0;

    fp_issue_ctrl #(
        .FP_LATENCY    (LAT),
        .ISSUE_GAP     (GAP),
        .NUM_REGS      (NR),
        .REGFILE_WIDTH (RW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_rs1       (dec_rs1),
        .dec_rs2       (dec_rs2),
        .dec_rs1_en    (dec_rs1_en),
        .dec_rs2_en    (dec_rs2_en),
        .dec_rd        (dec_rd),
        .dec_rd_en     (dec_rd_en),
        .fp_inst_valid (fp_inst_valid),
        .fex_busy      (fex_busy),
        .fex_busy_er   (fex_busy_er),
        .fex_result    (fex_result),
        .fex_err       (fex_err),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .wb_err        (wb_err),
        .proto_err     (proto_err),
        .stat_issued   (stat_issued),
        .stat_stall    (stat_stall)
    );

    always #5 clk = ~clk;

    // FEX model: busy = issue | issue-1cyc, early release = issue-1cyc.
    always @(posedge clk or posedge rst) begin
        if (rst) issue_d1 <= 1'b0;
        else     issue_d1 <= fp_inst_valid;
    end
    assign fex_busy    = force_busy_low ? 1'b0 : (fp_inst_valid | issue_d1);
    assign fex_busy_er = issue_d1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [IW-1:0] rd);
        exp_q.push_back('{rd: rd, due: cyc + LAT});
    endtask

    // Scoreboard side: every writeback must match the oldest expected entry.
    task automatic wb_check();
        exp_t e;
        if (wb_valid === 1'b1) begin
            wb_seen++;
            if (exp_q.size() == 0) begin
                chk("wb_unexpected_valid", wb_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("wb_rd", wb_rd, e.rd);
                chk("wb_cycle", cyc, e.due);
                chk("wb_data", wb_data, fex_result);
                chk("wb_err", wb_err, fex_err);
            end
        end else begin
            chk("idle_wb_data", wb_data, 32'h0);
            chk("idle_wb_err", wb_err, 1'b0);
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                chk("wb_missing", wb_valid, 1'b1);
                e = exp_q.pop_front();
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        wb_check();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
        fex_result     = {16'hA5A5, cyc[15:0]};
        fex_err        = 1'b0;
        force_busy_low = 1'b0;
    endtask

    task automatic op(input logic [IW-1:0] rs1, input logic rs1_en,
                      input logic [IW-1:0] rs2, input logic rs2_en,
                      input logic [IW-1:0] rd,  input logic rd_en);
        dec_valid  = 1'b1;
        dec_rs1    = rs1;
        dec_rs1_en = rs1_en;
        dec_rs2    = rs2;
        dec_rs2_en = rs2_en;
        dec_rd     = rd;
        dec_rd_en  = rd_en;
    endtask

    task automatic idle(input int n);
        dec_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            sample();
            adv();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b1;
        dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_rs1_en = 1'b0;
        dec_rs2_en = 1'b0; dec_rd = '0; dec_rd_en = 1'b0;
        fex_result = '0; fex_err = 1'b0; force_busy_low = 1'b0;
        @(posedge clk); #1;

        // Reset state
        sample();
        chk("rst_dec_ready", dec_ready, 1'b0);
        chk("rst_inst_valid", fp_inst_valid, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_proto_err", proto_err, 1'b0);
        chk("rst_stat_issued", stat_issued, 16'h0);
        chk("rst_stat_stall", stat_stall, 16'h0);
        adv();
        rst = 1'b0;
        sample();
        chk("post_rst_dec_ready", dec_ready, 1'b1);
        adv();

        // 1: independent ops rd=1 then rd=2
        op(5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1);
        sample(); chk("t1_ready_t0", dec_ready, 1'b1); chk("t1_issue_t0", fp_inst_valid, 1'b1); push(5'd1);
        adv();
        op(5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1);
        sample(); chk("t1_ready_t1", dec_ready, 1'b0); chk("t1_issue_t1", fp_inst_valid, 1'b0);
        adv();
        sample(); chk("t1_ready_t2", dec_ready, 1'b1); push(5'd2);
        adv();
        idle(4);
        chk("t1_proto_err", proto_err, 1'b0);
        chk("t1_drained", exp_q.size(), 0);

        // 2: RAW on rd=3
        op(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        sample(); chk("t2_ready_t0", dec_ready, 1'b1); push(5'd3);
        adv();
        op(5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1);
        sample(); chk("t2_raw_t1", dec_ready, 1'b0);
        adv();
        sample(); chk("t2_raw_t2", dec_ready, 1'b0);
        adv();
        sample(); chk("t2_raw_t3", dec_ready, 1'b1); push(5'd4);
        adv();
        idle(4);

        // 3: WAW on rd=5
        w0 = wb_seen;
        op(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        sample(); chk("t3_ready_t0", dec_ready, 1'b1); push(5'd5);
        adv();
        op(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        sample(); chk("t3_waw_t1", dec_ready, 1'b0);
        adv();
        sample(); chk("t3_waw_t2", dec_ready, 1'b0);
        adv();
        sample(); chk("t3_waw_t3", dec_ready, 1'b1); push(5'd5);
        adv();
        idle(4);
        chk("t3_wb_pulses", wb_seen - w0, 2);

        // rd_en=0 op occupies the pipe but leaves no pending bit
        op(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b0);
        sample(); chk("nord_ready_t0", dec_ready, 1'b1); push(5'd12);
        adv();
        op(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1);
        sample(); chk("nord_gap_t1", dec_ready, 1'b0);
        adv();
        sample(); chk("nord_no_pend_t2", dec_ready, 1'b1); push(5'd12);
        adv();
        idle(4);

        // 4: error and data at writeback, gated off afterwards
        op(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
        sample(); push(5'd6);
        adv();
        dec_valid = 1'b0;
        sample();
        adv();
        fex_result = 32'hDEADBEEF; fex_err = 1'b1;
        sample();
        chk("t4_wb_valid", wb_valid, 1'b1);
        chk("t4_wb_data", wb_data, 32'hDEADBEEF);
        chk("t4_wb_err", wb_err, 1'b1);
        adv();
        fex_result = 32'hDEADBEEF; fex_err = 1'b1;
        sample();
        chk("t4_next_valid", wb_valid, 1'b0);
        chk("t4_next_data", wb_data, 32'h0);
        chk("t4_next_err", wb_err, 1'b0);
        adv();
        idle(2);

        // 5: FEX drops busy in an issue cycle
        op(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        force_busy_low = 1'b1;
        sample(); chk("t5_issue", fp_inst_valid, 1'b1); chk("t5_proto_before", proto_err, 1'b0); push(5'd7);
        adv();
        dec_valid = 1'b0;
        sample(); chk("t5_proto_set", proto_err, 1'b1);
        adv();
        idle(4);
        chk("t5_proto_sticky", proto_err, 1'b1);

        // 6: reset one cycle after issue drops the op
        op(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1);
        sample(); chk("t6_issue", fp_inst_valid, 1'b1);
        adv();
        dec_valid = 1'b0;
        rst = 1'b1;
        sample(); chk("t6_rst_wb_valid", wb_valid, 1'b0);
        adv();
        rst = 1'b0;
        sample();
        chk("t6_ready", dec_ready, 1'b1);
        chk("t6_proto_cleared", proto_err, 1'b0);
        chk("t6_pend_empty", dut.u_scoreboard.pend_r, 32'h0);
        adv();
        idle(4);

        // Statistics: 3 issues and 4 stall cycles
        op(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        sample(); chk("st_issue1", dec_ready, 1'b1); push(5'd9);
        adv();
        op(5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1);
        sample(); chk("st_stall1", dec_ready, 1'b0);
        adv();
        sample(); chk("st_stall2", dec_ready, 1'b0);
        adv();
        sample(); chk("st_issue2", dec_ready, 1'b1); push(5'd10);
        adv();
        op(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1);
        sample(); chk("st_stall3", dec_ready, 1'b0);
        adv();
        sample(); chk("st_issue3", dec_ready, 1'b1); push(5'd11);
        adv();
        op(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1);
        sample(); chk("st_stall4", dec_ready, 1'b0);
        adv();
        dec_valid = 1'b0;
        sample();
        chk("stat_issued", stat_issued, EXP_ISSUED);
        chk("stat_stall", stat_stall, EXP_STALL);
        adv();
        idle(4);
        chk("final_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
